// File: rtl/time_base_counter.sv
// time_base_counter: 1 Hz time-of-day source. Divides CLK_50 down to a second
// boundary and keeps hour/minute/second in binary, with a user time load and a
// pause. Optional feature macro: HOURLY_CHIME_EN (adds the one-cycle chime
// output on each counting rollover to the top of the hour).
// CLK_FREQ_HZ must be at least 2 so the square-wave half point exists.
module time_base_counter #(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int unsigned HOURS_PER_DAY = 24
) (
    input  logic       CLK_50,
    input  logic       rst,
    input  logic       time_set,
    input  logic [5:0] hour_set,
    input  logic [5:0] minute_set,
    input  logic [5:0] second_set,
    input  logic       pause,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       one_second_clk,
    output logic       tick_1hz,
    output logic       day_wrap,
`ifdef HOURLY_CHIME_EN
    output logic       chime,
`endif
    output logic       set_err
);

    localparam int unsigned DIV_W  = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int unsigned TIME_W = 6;
    localparam logic [DIV_W-1:0]  DIV_TERM = DIV_W'(CLK_FREQ_HZ - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_FREQ_HZ / 2 - 1);
    localparam logic [TIME_W-1:0] HOUR_MAX = TIME_W'(HOURS_PER_DAY - 1);
    localparam logic [TIME_W-1:0] MS_MAX   = TIME_W'(59);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [TIME_W-1:0] hour_q, hour_d;
    logic [TIME_W-1:0] minute_q, minute_d;
    logic [TIME_W-1:0] second_q, second_d;
    logic              osc_q, osc_d;
    logic              tick_q, tick_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
`ifdef HOURLY_CHIME_EN
    logic              chime_q, chime_d;
`endif

    logic set_valid_c;
    logic sec_last_c, min_last_c, hour_last_c;

    assign set_valid_c = (hour_set <= HOUR_MAX) && (minute_set <= MS_MAX)
                         && (second_set <= MS_MAX);
    assign sec_last_c  = (second_q == MS_MAX);
    assign min_last_c  = (minute_q == MS_MAX);
    assign hour_last_c = (hour_q == HOUR_MAX);

    // Next-state: load beats pause beats counting; pulses default low.
    always_comb begin
        div_cnt_d = div_cnt_q;
        hour_d    = hour_q;
        minute_d  = minute_q;
        second_d  = second_q;
        osc_d     = osc_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
`ifdef HOURLY_CHIME_EN
        chime_d   = 1'b0;
`endif
        if (time_set) begin
            if (set_valid_c) begin
                hour_d    = hour_set;
                minute_d  = minute_set;
                second_d  = second_set;
                div_cnt_d = '0;
                osc_d     = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (!pause) begin
            if (div_cnt_q == DIV_TERM) begin
                div_cnt_d = '0;
                tick_d    = 1'b1;
                osc_d     = 1'b1;
                wrap_d    = sec_last_c && min_last_c && hour_last_c;
`ifdef HOURLY_CHIME_EN
                chime_d   = sec_last_c && min_last_c;
`endif
                if (sec_last_c) begin
                    second_d = '0;
                    if (min_last_c) begin
                        minute_d = '0;
                        hour_d   = hour_last_c ? '0 : hour_q + TIME_W'(1);
                    end else begin
                        minute_d = minute_q + TIME_W'(1);
                    end
                end else begin
                    second_d = second_q + TIME_W'(1);
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
                if (div_cnt_q == DIV_HALF) begin
                    osc_d = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK_50) begin
        if (rst) begin
            div_cnt_q <= '0;
            hour_q    <= '0;
            minute_q  <= '0;
            second_q  <= '0;
            osc_q     <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef HOURLY_CHIME_EN
            chime_q   <= 1'b0;
`endif
        end else begin
            div_cnt_q <= div_cnt_d;
            hour_q    <= hour_d;
            minute_q  <= minute_d;
            second_q  <= second_d;
            osc_q     <= osc_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
`ifdef HOURLY_CHIME_EN
            chime_q   <= chime_d;
`endif
        end
    end

    assign hour           = hour_q;
    assign minute         = minute_q;
    assign second         = second_q;
    assign one_second_clk = osc_q;
    assign tick_1hz       = tick_q;
    assign day_wrap       = wrap_q;
    assign set_err        = err_q;
`ifdef HOURLY_CHIME_EN
    assign chime          = chime_q;
`endif

endmodule

// File: tb/tb_time_base_counter.sv
// Bench for time_base_counter at CLK_FREQ_HZ=10: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a model
// that tracks time as total seconds in the day plus a phase within the second.
module tb_time_base_counter;

    localparam int F   = 10;
    localparam int HPD = 24;
    localparam int DAY = HPD * 3600;

    logic       clk = 1'b0;
    logic       rst, time_set, pause;
    logic [5:0] hour_set, minute_set, second_set;
    logic [5:0] hour, minute, second;
    logic       one_second_clk, tick_1hz, day_wrap, set_err;
`ifdef HOURLY_CHIME_EN
    logic       chime;
`endif

    time_base_counter #(.CLK_FREQ_HZ(F), .HOURS_PER_DAY(HPD)) dut (
        .CLK_50(clk), .rst(rst), .time_set(time_set),
        .hour_set(hour_set), .minute_set(minute_set), .second_set(second_set),
        .pause(pause), .hour(hour), .minute(minute), .second(second),
        .one_second_clk(one_second_clk), .tick_1hz(tick_1hz),
        .day_wrap(day_wrap),
`ifdef HOURLY_CHIME_EN
        .chime(chime),
`endif
        .set_err(set_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_tod, m_phase;
    bit m_seen, m_tick, m_wrap, m_err, m_chime;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_tick = 0; m_wrap = 0; m_err = 0; m_chime = 0;
        if (rst) begin
            m_tod = 0; m_phase = 0; m_seen = 0;
        end else if (time_set) begin
            if (int'(hour_set) < HPD && int'(minute_set) < 60 && int'(second_set) < 60) begin
                m_tod   = int'(hour_set) * 3600 + int'(minute_set) * 60 + int'(second_set);
                m_phase = 0;
                m_seen  = 0;
            end else begin
                m_err = 1;
            end
        end else if (!pause) begin
            m_phase++;
            if (m_phase == F) begin
                m_phase = 0;
                m_tod   = (m_tod + 1) % DAY;
                m_tick  = 1;
                m_seen  = 1;
                m_wrap  = (m_tod == 0);
                m_chime = (m_tod % 3600 == 0);
            end
        end
    endtask

    // one clock: model follows the edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("hour", int'(hour), m_tod / 3600);
        chk("minute", int'(minute), (m_tod / 60) % 60);
        chk("second", int'(second), m_tod % 60);
        chk("one_second_clk", int'(one_second_clk), int'(m_seen && (m_phase < F / 2)));
        chk("tick_1hz", int'(tick_1hz), int'(m_tick));
        chk("day_wrap", int'(day_wrap), int'(m_wrap));
        chk("set_err", int'(set_err), int'(m_err));
`ifdef HOURLY_CHIME_EN
        chk("chime", int'(chime), int'(m_chime));
`endif
    endtask

    task automatic drive(input bit r, input bit ts, input bit pz,
                         input int h, input int m, input int s);
        rst = r; time_set = ts; pause = pz;
        hour_set = 6'(h); minute_set = 6'(m); second_set = 6'(s);
    endtask

    typedef struct {
        bit r, ts, pz;
        int h, m, s;
        int eh, em, es;
        bit eerr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int cnt_tick, cnt_osc, cnt_wrap, n, got;
        bit frozen_bad;

        tbl[0] = '{1, 0, 0,  0,  0,  0,   0,  0,  0, 0};
        tbl[1] = '{0, 1, 0, 12, 60,  0,   0,  0,  0, 1};
        tbl[2] = '{0, 1, 0, 24,  0,  0,   0,  0,  0, 1};
        tbl[3] = '{0, 1, 0, 12, 34, 56,  12, 34, 56, 0};
        tbl[4] = '{0, 1, 0, 12,  0, 60,  12, 34, 56, 1};
        tbl[5] = '{1, 1, 0,  5,  6,  7,   0,  0,  0, 0};
        tbl[6] = '{0, 1, 0, 23, 59, 58,  23, 59, 58, 0};
        tbl[7] = '{0, 0, 1,  0,  0,  0,  23, 59, 58, 0};

        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);

        // directed vector table: each record is one edge
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].r, tbl[i].ts, tbl[i].pz, tbl[i].h, tbl[i].m, tbl[i].s);
            cycle();
            chk($sformatf("tbl%0d_hour", i), int'(hour), tbl[i].eh);
            chk($sformatf("tbl%0d_minute", i), int'(minute), tbl[i].em);
            chk($sformatf("tbl%0d_second", i), int'(second), tbl[i].es);
            chk($sformatf("tbl%0d_set_err", i), int'(set_err), int'(tbl[i].eerr));
            chk($sformatf("tbl%0d_tick", i), int'(tick_1hz), 0);
        end

        // reset then free run: second boundaries every 10 cycles, 5/5 square wave
        drive(1, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0);
        cnt_tick = 0; cnt_osc = 0;
        for (int c = 1; c <= 25; c++) begin
            cycle();
            cnt_tick += int'(tick_1hz);
            if (c >= 10 && c <= 19) cnt_osc += int'(one_second_clk);
            if (c == 9)  chk("seq1_sec_c9", int'(second), 0);
            if (c == 10) chk("seq1_sec_c10", int'(second), 1);
            if (c == 20) chk("seq1_sec_c20", int'(second), 2);
        end
        chk("seq1_tick_count", cnt_tick, 2);
        chk("seq1_osc_high", cnt_osc, 5);

        // day rollover from a load
        drive(0, 1, 0, 23, 59, 58); cycle();
        drive(0, 0, 0, 0, 0, 0);
        cnt_wrap = 0;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (c == 10) chk("seq2_sec_c10", int'(second), 59);
            if (day_wrap) begin
                cnt_wrap++;
                chk("seq2_wrap_time", int'(hour) * 3600 + int'(minute) * 60 + int'(second), 0);
            end
        end
        chk("seq2_wrap_count", cnt_wrap, 1);
        chk("seq2_final_hour", int'(hour), 0);

        // pause mid-second with the square wave high
        drive(1, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 14; c++) cycle();
        chk("seq4_osc_before", int'(one_second_clk), 1);
        drive(0, 0, 1, 0, 0, 0);
        frozen_bad = 0;
        for (int c = 0; c < 37; c++) begin
            cycle();
            if (second != 6'd1 || one_second_clk != 1'b1 || tick_1hz != 1'b0) frozen_bad = 1;
        end
        chk("seq4_frozen", int'(frozen_bad), 0);
        drive(0, 0, 0, 0, 0, 0);
        got = -1;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (tick_1hz) begin got = c; break; end
        end
        chk("seq4_tick_after_pause", got, 6);

        // reset wins over an in-range load
        drive(1, 1, 0, 5, 6, 7); cycle();
        chk("seq5_time", int'(hour) * 3600 + int'(minute) * 60 + int'(second), 0);
        chk("seq5_set_err", int'(set_err), 0);
        drive(0, 0, 0, 0, 0, 0);

`ifdef HOURLY_CHIME_EN
        drive(0, 1, 0, 0, 59, 58); cycle();
        drive(0, 0, 0, 0, 0, 0);
        n = 0;
        for (int c = 1; c <= 25; c++) begin
            cycle();
            if (chime) begin
                n++;
                chk("seq6_chime_time", int'(hour) * 3600 + int'(minute) * 60 + int'(second), 3600);
            end
        end
        chk("seq6_chime_count", n, 1);
`endif

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int sel;
            sel = int'($urandom_range(0, 999));
            if (sel < 5) begin
                drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
            end else if (sel < 40) begin
                int k;
                k = int'($urandom_range(0, 3));
                if (k < 2)
                    drive(0, 1, $urandom_range(0, 1), $urandom_range(0, HPD - 1), 59,
                          $urandom_range(55, 59));
                else if (k == 2)
                    drive(0, 1, 0, $urandom_range(0, 63), $urandom_range(0, 63),
                          $urandom_range(0, 63));
                else
                    drive(0, 1, 0, $urandom_range(0, HPD - 1), $urandom_range(0, 59),
                          $urandom_range(0, 59));
            end else begin
                drive(0, 0, ($urandom_range(0, 4) == 0), 0, 0, 0);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
